mem_responder: RTL and testbench

Memory-side responder for the CPU core's two external buses. It serves 24-bit microinstruction fetches on the ROM port, driving data plus a valid flag back to the microsequencer. It also serves 8-bit reads and writes on the shared RAM data bus, using the CPU's active-low read and write strobes. It sits outside the CPU top level and replaces the board ROM/RAM in simulation and on FPGA. A loader port fills the microcode store before run.

---
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: registered microcode ROM fetch FSM plus zero-latency RAM port.
// Optional slow-ROM wait states are built when MEM_RESP_WAIT_EN is defined.
module mem_responder #(
    parameter int ROM_DEPTH   = 256,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr_rom,
    output logic [23:0] in_rom,
    output logic        in_rom_efficient,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [23:0] load_data,
    input  logic [7:0]  addr_ram,
    inout  wire  [7:0]  dataram,
    input  logic        wram,
    input  logic        rram,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_READY
    } state_t;

    logic [23:0] rom_mem [ROM_DEPTH];
    logic [7:0]  ram_mem [RAM_DEPTH];

    state_t      state_q, state_d;
    logic [7:0]  last_addr_q, last_addr_d;
    logic [23:0] in_rom_q, in_rom_d;
    logic        valid_q, valid_d;
    logic        bus_err_q, bus_err_d;
    logic        addr_chg;
    logic        start;
    logic        fetch_done;

    assign addr_chg = (addr_rom != last_addr_q);
    assign start    = !load_en &&
                      (state_q == S_IDLE || state_q == S_LOAD ||
                       (state_q == S_READY && addr_chg));

`ifdef MEM_RESP_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = WAIT_LD;
        end else if (!load_en && state_q == S_FETCH && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_done = (cnt_q == 4'd0);
`else
    logic [3:0] unused_wait;

    assign unused_wait = 4'(WAIT_CYCLES);
    assign fetch_done  = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        in_rom_d    = in_rom_q;
        valid_d     = valid_q;
        bus_err_d   = bus_err_q | (!wram && !rram);
        if (load_en) begin
            valid_d = 1'b0;
            state_d = S_LOAD;
        end else begin
            unique case (state_q)
                S_IDLE, S_LOAD: begin
                    last_addr_d = addr_rom;
                    state_d     = S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_done) begin
                        in_rom_d = rom_mem[last_addr_q];
                        valid_d  = 1'b1;
                        state_d  = S_READY;
                    end
                end
                S_READY: begin
                    // Drop valid on the same edge that sees the new address
                    if (addr_chg) begin
                        valid_d     = 1'b0;
                        last_addr_d = addr_rom;
                        state_d     = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_addr_q <= 8'd0;
            in_rom_q    <= 24'd0;
            valid_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            in_rom_q    <= in_rom_d;
            valid_q     <= valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Memory contents survive reset; only RAM writes are gated by it
    always_ff @(posedge clk) begin
        if (load_en) begin
            rom_mem[load_addr] <= load_data;
        end
        if (!rst && !wram) begin
            ram_mem[addr_ram] <= dataram;
        end
    end

    assign dataram = (!rram && wram) ? ram_mem[addr_ram] : 8'bz;

    assign in_rom           = in_rom_q;
    assign in_rom_efficient = valid_q;
    assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized ROM fetch and RAM traffic vs a reference model.
// Works with or without MEM_RESP_WAIT_EN defined.
module tb_mem_responder;

    localparam int W = 3;
`ifdef MEM_RESP_WAIT_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  addr_rom;
    logic [23:0] in_rom;
    logic        in_rom_efficient;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [23:0] load_data;
    logic [7:0]  addr_ram;
    wire  [7:0]  dataram;
    logic        wram;
    logic        rram;
    logic        bus_err;
    logic        tb_oe;
    logic [7:0]  tb_drv;

    int checks;
    int failures;

    logic [23:0] rom_m [256];
    logic [7:0]  ram_m [256];
    logic [7:0]  rom_list [$];
    logic [7:0]  cur;

    assign dataram = tb_oe ? tb_drv : 8'bz;

    mem_responder #(
        .ROM_DEPTH  (256),
        .RAM_DEPTH  (256),
        .WAIT_CYCLES(W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .addr_rom        (addr_rom),
        .in_rom          (in_rom),
        .in_rom_efficient(in_rom_efficient),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .addr_ram        (addr_ram),
        .dataram         (dataram),
        .wram            (wram),
        .rram            (rram),
        .bus_err         (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [23:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
        rom_m[a]  = d;
        rom_list.push_back(a);
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
        addr_ram = a;
        tb_drv   = d;
        tb_oe    = 1'b1;
        wram     = 1'b0;
        step();
        wram     = 1'b1;
        tb_oe    = 1'b0;
        ram_m[a] = d;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (in_rom !== 24'd0) begin
            failures++;
            $display("FAIL reset_in_rom got=%h want=000000", in_rom);
        end
        checks++;
        if (in_rom_efficient !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", in_rom_efficient);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus_err got=%b want=0", bus_err);
        end
    endtask

    task automatic test_boot_fetch();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            load_word(8'($urandom_range(0, 255)), 24'($urandom));
        end
        load_word(8'h06, 24'($urandom));
        load_word(8'h05, 24'h2A1234);
        rst      = 1'b1;
        addr_rom = 8'h05;
        cur      = 8'h05;
        repeat (2) step();
        rst = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            checks++;
            if (in_rom_efficient !== (e == LAT + 1)) begin
                failures++;
                $display("FAIL boot_valid edge=%0d got=%b want=%b",
                         e, in_rom_efficient, (e == LAT + 1));
            end
        end
        checks++;
        if (in_rom !== 24'h2A1234) begin
            failures++;
            $display("FAIL boot_word got=%h want=2a1234", in_rom);
        end
    endtask

    task automatic test_addr_change();
        logic [7:0] nxt;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                nxt = 8'h06;
            end else begin
                nxt = cur;
                while (nxt == cur) begin
                    nxt = rom_list[$urandom_range(0, rom_list.size() - 1)];
                end
            end
            addr_rom = nxt;
            cur      = nxt;
            for (int e = 1; e <= LAT + 1; e++) begin
                step();
                checks++;
                if (in_rom_efficient !== (e == LAT + 1)) begin
                    failures++;
                    $display("FAIL chg_valid addr=%h edge=%0d got=%b want=%b",
                             nxt, e, in_rom_efficient, (e == LAT + 1));
                end
            end
            checks++;
            if (in_rom !== rom_m[nxt]) begin
                failures++;
                $display("FAIL chg_word addr=%h got=%h want=%h",
                         nxt, in_rom, rom_m[nxt]);
            end
            repeat (2) step();
            checks++;
            if (in_rom_efficient !== 1'b1 || in_rom !== rom_m[nxt]) begin
                failures++;
                $display("FAIL chg_hold addr=%h got=%b/%h want=1/%h",
                         nxt, in_rom_efficient, in_rom, rom_m[nxt]);
            end
        end
    endtask

    task automatic test_ram();
        logic [7:0] a;
        logic [7:0] list [$];
        ram_write(8'h10, 8'h5A);
        list.push_back(8'h10);
        rram     = 1'b0;
        addr_ram = 8'h10;
        #1;
        checks++;
        if (dataram !== 8'h5A) begin
            failures++;
            $display("FAIL ram_read_5a got=%h want=5a", dataram);
        end
        rram = 1'b1;
        #1;
        checks++;
        if (!(dataram === 8'hzz || dataram === 8'h00)) begin
            failures++;
            $display("FAIL ram_release got=%h want=zz", dataram);
        end
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom_range(0, 255));
            if (a == 8'h20 || a == 8'h33) a = 8'h40;
            ram_write(a, 8'($urandom_range(1, 255)));
            list.push_back(a);
        end
        for (int i = 0; i < 8; i++) begin
            a        = list[$urandom_range(0, list.size() - 1)];
            addr_ram = a;
            rram     = 1'b0;
            #1;
            checks++;
            if (dataram !== ram_m[a]) begin
                failures++;
                $display("FAIL ram_read addr=%h got=%h want=%h",
                         a, dataram, ram_m[a]);
            end
            @(negedge clk);
            rram = 1'b1;
        end
    endtask

    task automatic test_bus_err();
        addr_ram = 8'h20;
        tb_drv   = 8'h77;
        tb_oe    = 1'b1;
        wram     = 1'b0;
        rram     = 1'b0;
        #1;
        checks++;
        if (dataram !== 8'h77) begin
            failures++;
            $display("FAIL both_low_bus got=%h want=77", dataram);
        end
        step();
        wram = 1'b1;
        rram = 1'b1;
        tb_oe = 1'b0;
        ram_m[8'h20] = 8'h77;
        checks++;
        if (bus_err !== 1'b1) begin
            failures++;
            $display("FAIL bus_err_set got=%b want=1", bus_err);
        end
        rram = 1'b0;
        #1;
        checks++;
        if (dataram !== 8'h77) begin
            failures++;
            $display("FAIL both_low_write got=%h want=77", dataram);
        end
        wram = 1'b0;
        #1;
        checks++;
        if (!(dataram === 8'hzz || dataram === 8'h00)) begin
            failures++;
            $display("FAIL both_low_undriven got=%h want=zz", dataram);
        end
        wram = 1'b1;
        rram = 1'b1;
        @(negedge clk);
        repeat (4) step();
        checks++;
        if (bus_err !== 1'b1) begin
            failures++;
            $display("FAIL bus_err_sticky got=%b want=1", bus_err);
        end
    endtask

    task automatic test_reset_ram_block();
        ram_write(8'h33, 8'h11);
        rst      = 1'b1;
        addr_ram = 8'h33;
        tb_drv   = 8'hC3;
        tb_oe    = 1'b1;
        wram     = 1'b0;
        step();
        wram  = 1'b1;
        tb_oe = 1'b0;
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL bus_err_clear got=%b want=0", bus_err);
        end
        rst  = 1'b0;
        rram = 1'b0;
        #1;
        checks++;
        if (dataram !== ram_m[8'h33]) begin
            failures++;
            $display("FAIL ram_write_in_reset got=%h want=%h",
                     dataram, ram_m[8'h33]);
        end
        rram = 1'b1;
        repeat (LAT + 2) step();
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] nxt;
        nxt = cur;
        while (nxt == cur) begin
            nxt = rom_list[$urandom_range(0, rom_list.size() - 1)];
        end
        addr_rom = nxt;
        cur      = nxt;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (in_rom !== 24'd0 || in_rom_efficient !== 1'b0) begin
            failures++;
            $display("FAIL midfetch_reset got=%h/%b want=000000/0",
                     in_rom, in_rom_efficient);
        end
        rst = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            checks++;
            if (in_rom_efficient !== (e == LAT + 1)) begin
                failures++;
                $display("FAIL midfetch_restart edge=%0d got=%b want=%b",
                         e, in_rom_efficient, (e == LAT + 1));
            end
        end
        checks++;
        if (in_rom !== rom_m[nxt]) begin
            failures++;
            $display("FAIL midfetch_word got=%h want=%h", in_rom, rom_m[nxt]);
        end
    endtask

    task automatic test_load_refetch();
        if (cur != 8'h06) begin
            addr_rom = 8'h06;
            cur      = 8'h06;
            repeat (LAT + 2) step();
        end
        checks++;
        if (in_rom_efficient !== 1'b1 || in_rom !== rom_m[8'h06]) begin
            failures++;
            $display("FAIL load_pre got=%b/%h want=1/%h",
                     in_rom_efficient, in_rom, rom_m[8'h06]);
        end
        load_word(8'h06, 24'hFFFFFF);
        checks++;
        if (in_rom_efficient !== 1'b0) begin
            failures++;
            $display("FAIL load_drop got=%b want=0", in_rom_efficient);
        end
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            checks++;
            if (in_rom_efficient !== (e == LAT + 1)) begin
                failures++;
                $display("FAIL load_refetch edge=%0d got=%b want=%b",
                         e, in_rom_efficient, (e == LAT + 1));
            end
        end
        checks++;
        if (in_rom !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL load_word got=%h want=ffffff", in_rom);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        addr_rom  = 8'h00;
        load_en   = 1'b0;
        load_addr = 8'h00;
        load_data = 24'h0;
        addr_ram  = 8'h00;
        wram      = 1'b1;
        rram      = 1'b1;
        tb_oe     = 1'b0;
        tb_drv    = 8'h00;
        cur       = 8'h00;
        test_reset();
        test_boot_fetch();
        test_addr_change();
        test_ram();
        test_bus_err();
        test_reset_ram_block();
        test_reset_mid_fetch();
        test_load_refetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
